hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port id_rs, input, 5: rs field of the instruction in ID.
REQ-005 The block SHALL have port id_rt, input, 5: rt field of the instruction in ID.
REQ-006 The block SHALL have port ex_mem_read, input, 1: the instruction in EX is a load.
REQ-007 The block SHALL have port ex_rt, input, 5: destination rt of the instruction in EX.
REQ-008 The block SHALL have port branch_taken, input, 1: a branch in ID resolved taken.
REQ-009 The block SHALL have port jump, input, 1: a jump is in ID.
REQ-010 The block SHALL have port dmem_busy, input, 1: data memory requests a pipeline freeze.
REQ-011 The block SHALL have port pc_write, output, 1: PC load enable.
REQ-012 The block SHALL have port if_id_write, output, 1: IF/ID register load enable.
REQ-013 The block SHALL have port if_flush, output, 1: IF/ID register captures a nop (all-zero instruction).
REQ-014 The block SHALL have port id_ex_bubble, output, 1: ID/EX register control fields are forced to zero.
REQ-015 The block SHALL have port freeze, output, 1: EX/MEM and MEM/WB registers hold their contents.
REQ-016 The block SHALL have port stall_cnt, output, CNT_W: saturating count of stall cycles.
REQ-017 The block SHALL have port flush_cnt, output, CNT_W: saturating count of flush cycles.

Function
REQ-018 The FSM SHALL have states RUN, MEM_WAIT and REDIRECT.
REQ-019 A load-use hazard SHALL be defined as ex_mem_read=1, ex_rt!=0, and ex_rt equal to id_rs or to id_rt.
REQ-020 In RUN with dmem_busy=1, the block SHALL drive freeze=1, pc_write=0 and if_id_write=0 in the same cycle, and SHALL go to MEM_WAIT.
REQ-021 In MEM_WAIT, the block SHALL hold freeze=1, pc_write=0 and if_id_write=0 while dmem_busy=1, and SHALL return to RUN in the cycle after dmem_busy falls; all other inputs are ignored in MEM_WAIT.
REQ-022 In RUN with a load-use hazard and no dmem_busy, the block SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1 and if_flush=0 for exactly that cycle, and SHALL remain in RUN.
REQ-023 In RUN with (branch_taken or jump), no hazard and no dmem_busy, the block SHALL drive if_flush=1 with pc_write=1 and if_id_write=1, and SHALL go to REDIRECT.
REQ-024 In REDIRECT, the block SHALL drive normal enables with if_flush=0, SHALL ignore branch_taken and jump for one cycle (the delay-slot nop), and SHALL return to RUN; dmem_busy in REDIRECT SHALL take the REQ-020 path.
REQ-025 Priority SHALL be dmem_busy, then load-use, then branch/jump; a flush coincident with a load-use hazard SHALL be suppressed and re-evaluated on the next cycle.
REQ-026 With no event, the block SHALL drive pc_write=1, if_id_write=1, if_flush=0, id_ex_bubble=0 and freeze=0.
REQ-027 Control outputs SHALL be combinational from the state and the current inputs, with no added latency.
REQ-028 stall_cnt SHALL increment once per cycle in which pc_write=0; flush_cnt SHALL increment once per cycle in which if_flush=1.
REQ-029 Both counters SHALL saturate at all-ones and SHALL not wrap.

Reset
REQ-030 While rst_n=0, the block SHALL drive state=RUN, stall_cnt=0, flush_cnt=0, pc_write=0, if_id_write=0, if_flush=1, id_ex_bubble=1 and freeze=0.
REQ-031 Reset asserted mid-MEM_WAIT or mid-REDIRECT SHALL abort to RUN immediately.
REQ-032 After release, the first clock edge SHALL evaluate from RUN.

Structure
REQ-033 The state encoding (2-bit: RUN=0, MEM_WAIT=1, REDIRECT=2) and the register-zero constant SHALL live in the shared pipeline package.
REQ-034 One sub-module, sat_counter (parameter CNT_W, ports inc and count), SHALL be instantiated twice, once per counter.

Verification
REQ-035 The bench SHALL apply lw with ex_rt=5 in EX and id_rs=5, and SHALL check one cycle of pc_write=0, if_id_write=0 and id_ex_bubble=1, with stall_cnt going 0->1.
REQ-036 The bench SHALL apply ex_rt=0 with ex_mem_read=1 and id_rt=0, and SHALL check that no stall occurs.
REQ-037 The bench SHALL apply branch_taken=1 for 2 cycles, and SHALL check if_flush=1 in cycle 1 only and flush_cnt=1.
REQ-038 The bench SHALL apply branch_taken together with a load-use hazard, and SHALL check the stall first with no flush, then if_flush=1 on the next cycle.
REQ-039 The bench SHALL hold dmem_busy for 3 cycles, and SHALL check freeze=1 for 3 cycles, stall_cnt=3 and RUN on the 4th cycle.
REQ-040 The bench SHALL preload stall_cnt near all-ones with CNT_W=4, run 20 stall cycles, and SHALL check stall_cnt=15; it SHALL then pulse rst_n low mid-MEM_WAIT and check all outputs at their REQ-030 values immediately.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encoding,
// register-zero constant and the load-use detection rule.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hazard_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt
  );
    return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, load-use stall and branch/jump
// flush sequencing, plus saturating stall/flush event counters.
//
// state    | meaning
// RUN      | normal issue; evaluates dmem_busy > load-use > branch/jump
// MEM_WAIT | pipeline frozen until data memory drops dmem_busy
// REDIRECT | delay-slot nop in ID; branch/jump ignored for this cycle
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             id_ex_bubble,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_e state, state_nxt;
  logic          hazard;

  assign hazard = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_flush     = 1'b0;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;

    // Outputs follow rst_n directly so the pipeline is held safe while in reset.
    if (!rst_n) begin
      state_nxt    = RUN;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_flush     = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        MEM_WAIT: begin
          if (dmem_busy) begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else begin
            state_nxt = RUN;
          end
        end
        REDIRECT: begin
          if (dmem_busy) begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_nxt   = MEM_WAIT;
          end else begin
            state_nxt = RUN;
          end
        end
        default: begin
          if (dmem_busy) begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_nxt   = MEM_WAIT;
          end else if (hazard) begin
            // A coincident branch/jump stays in ID and is re-seen next cycle.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (branch_taken || jump) begin
            if_flush  = 1'b1;
            state_nxt = REDIRECT;
          end
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a behavioural model checked every cycle
// plus hand-computed literal expectations at key points.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       id_rs = '0;
  logic [4:0]       id_rt = '0;
  logic             ex_mem_read = 1'b0;
  logic [4:0]       ex_rt = '0;
  logic             branch_taken = 1'b0;
  logic             jump = 1'b0;
  logic             dmem_busy = 1'b0;
  logic             pc_write, if_id_write, if_flush, id_ex_bubble, freeze;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // model: "frozen on memory" and "delay slot pending" flags plus event tallies
  bit m_mem_wait = 1'b0;
  bit m_slot     = 1'b0;
  int m_stalls   = 0;
  int m_flushes  = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .dmem_busy    (dmem_busy),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_flush     (if_flush),
    .id_ex_bubble (id_ex_bubble),
    .freeze       (freeze),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int  e_pc, e_ifid, e_fl, e_bub, e_frz;
    bit  dep;
    if (!rst_n) begin
      m_mem_wait = 1'b0;
      m_slot     = 1'b0;
      m_stalls   = 0;
      m_flushes  = 0;
      e_pc = 0; e_ifid = 0; e_fl = 1; e_bub = 1; e_frz = 0;
    end else begin
      e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; e_frz = 0;
      dep = ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
      if (dmem_busy && (m_mem_wait || 1'b1)) begin
        e_pc = 0; e_ifid = 0; e_frz = 1;
        m_mem_wait = 1'b1;
        m_slot     = 1'b0;
      end else if (m_mem_wait) begin
        m_mem_wait = 1'b0;
      end else if (m_slot) begin
        m_slot = 1'b0;
      end else if (dep) begin
        e_pc = 0; e_ifid = 0; e_bub = 1;
      end else if (branch_taken || jump) begin
        e_fl   = 1;
        m_slot = 1'b1;
      end
    end
    chk("pc_write",     int'(pc_write),     e_pc);
    chk("if_id_write",  int'(if_id_write),  e_ifid);
    chk("if_flush",     int'(if_flush),     e_fl);
    chk("id_ex_bubble", int'(id_ex_bubble), e_bub);
    chk("freeze",       int'(freeze),       e_frz);
    chk("stall_cnt",    int'(stall_cnt),    m_stalls);
    chk("flush_cnt",    int'(flush_cnt),    m_flushes);
    if (rst_n) begin
      if (e_pc == 0 && m_stalls < SAT) m_stalls++;
      if (e_fl == 1 && m_flushes < SAT) m_flushes++;
    end
  endtask

  // Model check mid-cycle, then move to 2 time units after the next rising edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_mem_read = 1'b0; ex_rt = '0;
    branch_taken = 1'b0; jump = 1'b0; dmem_busy = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_if_flush", int'(if_flush), 1);
    chk("rst_bubble",   int'(id_ex_bubble), 1);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_pc_write", int'(pc_write), 1);
    chk("idle_flush", int'(if_flush), 0);
    tick();

    // load-use on rs
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_if_id_write", int'(if_id_write), 0);
    chk("lu_bubble", int'(id_ex_bubble), 1);
    chk("lu_stall_before", int'(stall_cnt), 0);
    tick();
    idle();
    #1;
    chk("lu_stall_after", int'(stall_cnt), 1);
    chk("lu_released", int'(pc_write), 1);
    tick();

    // load into r0 is never a dependency
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rt = 5'd0; id_rs = 5'd0;
    #1;
    chk("r0_pc_write", int'(pc_write), 1);
    chk("r0_bubble", int'(id_ex_bubble), 0);
    tick();
    idle();
    #1;
    chk("r0_stall_cnt", int'(stall_cnt), 1);

    // branch held for two cycles flushes only once
    branch_taken = 1'b1;
    #1;
    chk("br1_flush", int'(if_flush), 1);
    chk("br1_pc_write", int'(pc_write), 1);
    tick();
    #1;
    chk("br2_flush", int'(if_flush), 0);
    tick();
    idle();
    #1;
    chk("br_flush_cnt", int'(flush_cnt), 1);
    tick();

    // branch with load-use on rt: stall first, flush next cycle
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7;
    #1;
    chk("combo_flush_sup", int'(if_flush), 0);
    chk("combo_bubble", int'(id_ex_bubble), 1);
    chk("combo_pc_write", int'(pc_write), 0);
    tick();
    ex_mem_read = 1'b0; ex_rt = '0; id_rt = '0;
    #1;
    chk("combo_flush", int'(if_flush), 1);
    tick();
    idle();
    tick();
    #1;
    chk("combo_stall_cnt", int'(stall_cnt), 2);
    chk("combo_flush_cnt", int'(flush_cnt), 2);

    // three cycles of memory freeze; jump ignored on the release cycle
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_freeze", int'(freeze), 1);
      tick();
    end
    dmem_busy = 1'b0; jump = 1'b1;
    #1;
    chk("busy_rel_freeze", int'(freeze), 0);
    chk("busy_rel_pc_write", int'(pc_write), 1);
    chk("busy_rel_no_flush", int'(if_flush), 0);
    chk("busy_stall_cnt", int'(stall_cnt), 5);
    tick();
    #1;
    chk("jump_flush", int'(if_flush), 1);
    tick();
    idle();
    tick();
    #1;
    chk("jump_flush_cnt", int'(flush_cnt), 3);

    // 20 more stall cycles must saturate the 4-bit counter
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    idle();
    #1;
    chk("sat_stall_cnt", int'(stall_cnt), SAT);
    tick();

    // reset pulse while frozen in MEM_WAIT
    dmem_busy = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc_write", int'(pc_write), 0);
    chk("mid_rst_if_id_write", int'(if_id_write), 0);
    chk("mid_rst_if_flush", int'(if_flush), 1);
    chk("mid_rst_bubble", int'(id_ex_bubble), 1);
    chk("mid_rst_freeze", int'(freeze), 0);
    chk("mid_rst_stall_cnt", int'(stall_cnt), 0);
    chk("mid_rst_flush_cnt", int'(flush_cnt), 0);
    tick();
    dmem_busy = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_pc_write", int'(pc_write), 1);
    chk("post_rst_freeze", int'(freeze), 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
